// File: rtl/usf_unfold_if.sv
// Stream bundle for the unfolding stage: folded ADC codes in, reconstructed
// samples out. The DUT side uses the slave modport; the master modport is the
// view of whatever sits on the other end of both channels.
interface usf_unfold_if #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_skip;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_hold;

    modport master (
        output in_valid, in_data, in_skip, out_ready,
        input  in_ready, out_valid, out_data, out_hold
    );

    modport slave (
        input  in_valid, in_data, in_skip, out_ready,
        output in_ready, out_valid, out_data, out_hold
    );
endinterface

// File: rtl/usf_unfold.sv
// First-order modulo unfolding for unlimited-sampling reconstruction.
// Stage 1 centres each code, differences it against the previous kept sample
// and wraps the difference into [-lambda, lambda). Stage 2 accumulates the
// wrapped differences into a saturating signed sample. DEC-marked samples are
// emitted as holds and leave the unfolding state untouched.
// OUT_W must be at least DATA_W + 2 so every stage-1 value sign-extends into
// the accumulator.
module usf_unfold #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 20,
    parameter int OFFSET = 2048,
    parameter int CNT_W  = 16
) (
    input  logic              adc_clk,
    input  logic              adc_reset,
    input  logic              restart,
    input  logic [DATA_W-1:0] fold_range,
    usf_unfold_if.slave       bus,
    output logic [CNT_W-1:0]  fold_count,
    output logic              sat_flag
);
    localparam int YW = DATA_W + 1;   // centred sample
    localparam int DW = DATA_W + 2;   // first difference
    localparam int SW = OUT_W + 1;    // accumulator sum before clipping

    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic signed [SW-1:0] ACC_MAX = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {2'b11, {(OUT_W-1){1'b0}}};
    localparam logic [YW-1:0]        OFFSET_Y = YW'(OFFSET);
    localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

    logic clr;
    logic en;
    logic xfer;

    logic [0:0] state;
    logic signed [YW-1:0] y;
    logic signed [YW-1:0] y_prev;
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] dw;
    logic signed [DW-1:0] lam;
    logic signed [DW-1:0] two_lam;
    logic                 wrap;

    logic                 s1_valid;
    logic signed [DW-1:0] s1_dw;
    logic signed [YW-1:0] s1_y;
    logic                 s1_skip;
    logic                 s1_first;
    logic                 s1_wrap;

    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] acc_next;
    logic signed [SW-1:0]    sum;
    logic                    clip;
    logic                    out_valid_q;
    logic                    out_hold_q;

    // Bit 0 of the range is meaningless: the range is always an even 2*lambda.
    logic unused_range_lsb;
    assign unused_range_lsb = fold_range[0];

    // Restart behaves exactly like reset for everything it touches, and wins
    // over any input transfer in the same cycle.
    assign clr  = adc_reset | restart;
    assign en   = ~out_valid_q | bus.out_ready;
    assign xfer = bus.in_valid & en;

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.out_hold  = out_hold_q;

    assign lam     = {3'b000, fold_range[DATA_W-1:1]};
    assign two_lam = {2'b00, fold_range[DATA_W-1:1], 1'b0};

    // Stage 1 arithmetic: centre, difference, single modulo correction.
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        y    = $signed({1'b0, bus.in_data} - OFFSET_Y);
        d    = $signed({y[YW-1], y} - {y_prev[YW-1], y_prev});
        dw   = d;
        wrap = 1'b0;
        if (d >= lam) begin
            dw   = d - two_lam;
            wrap = 1'b1;
        end else if (d < -lam) begin
            dw   = d + two_lam;
            wrap = 1'b1;
        end
    end

    // Stage 1 control: valid flag, previous kept sample and FIRST/RUN state.
    // NOTE: state is updated with non-blocking assignments so every register
    // in the design sees the pre-edge values of the others.
    always_ff @(posedge adc_clk) begin
        if (clr) begin
            s1_valid <= 1'b0;
            y_prev   <= '0;
            state    <= ST_FIRST;
        end else if (xfer) begin
            s1_valid <= 1'b1;
            if (!bus.in_skip) begin
                y_prev <= y;
                state  <= ST_RUN;
            end
        end else if (en) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload, captured on every transfer.
    // NOTE: payload registers carry no reset; they are only ever read while
    // s1_valid is set, and s1_valid is reset.
    always_ff @(posedge adc_clk) begin
        if (xfer) begin
            s1_dw    <= dw;
            s1_y     <= y;
            s1_skip  <= bus.in_skip;
            s1_first <= (state == ST_FIRST);
            s1_wrap  <= wrap;
        end
    end

    // Stage 2 arithmetic: saturating accumulate of the wrapped difference.
    always_comb begin
        sum      = $signed({acc[OUT_W-1], acc}) + $signed({{(SW-DW){s1_dw[DW-1]}}, s1_dw});
        acc_next = sum[OUT_W-1:0];
        clip     = 1'b0;
        if (sum > ACC_MAX) begin
            acc_next = ACC_MAX[OUT_W-1:0];
            clip     = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_next = ACC_MIN[OUT_W-1:0];
            clip     = 1'b1;
        end
    end

    // Stage 2 registers: output sample, hold marker, fold counter, clip flag.
    always_ff @(posedge adc_clk) begin
        if (clr) begin
            out_valid_q <= 1'b0;
            out_hold_q  <= 1'b0;
            acc         <= '0;
            fold_count  <= '0;
            sat_flag    <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                if (s1_skip) begin
                    // A hold repeats the last output; before any kept sample
                    // that output is zero.
                    out_hold_q <= 1'b1;
                    if (s1_first) begin
                        acc <= '0;
                    end
                end else if (s1_first) begin
                    out_hold_q <= 1'b0;
                    acc        <= {{(OUT_W-YW){s1_y[YW-1]}}, s1_y};
                end else begin
                    out_hold_q <= 1'b0;
                    acc        <= acc_next;
                    if (clip) begin
                        sat_flag <= 1'b1;
                    end
                    if (s1_wrap && fold_count != CNT_MAX) begin
                        fold_count <= fold_count + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usf_unfold.sv
// Bench for usf_unfold. Two instances (OUT_W 20 and 14) see the same stimulus;
// an integer model of the unfolding rules predicts every output, and a single
// negedge process compares each consumed output against it.
module tb_usf_unfold;
    logic        adc_clk = 1'b0;
    logic        adc_reset;
    logic        restart;
    logic [11:0] fold_range;
    logic        in_valid;
    logic        in_skip;
    logic [11:0] in_data;
    logic        out_ready;
    logic [15:0] fc_a, fc_b;
    logic        sat_a, sat_b;

    usf_unfold_if #(.DATA_W(12), .OUT_W(20)) ifa ();
    usf_unfold_if #(.DATA_W(12), .OUT_W(14)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.in_skip   = in_skip;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.in_skip   = in_skip;
    assign ifb.out_ready = out_ready;

    usf_unfold #(.DATA_W(12), .OUT_W(20), .OFFSET(2048), .CNT_W(16)) dut_a (
        .adc_clk    (adc_clk),
        .adc_reset  (adc_reset),
        .restart    (restart),
        .fold_range (fold_range),
        .bus        (ifa),
        .fold_count (fc_a),
        .sat_flag   (sat_a)
    );

    usf_unfold #(.DATA_W(12), .OUT_W(14), .OFFSET(2048), .CNT_W(16)) dut_b (
        .adc_clk    (adc_clk),
        .adc_reset  (adc_reset),
        .restart    (restart),
        .fold_range (fold_range),
        .bus        (ifb),
        .fold_count (fc_b),
        .sat_flag   (sat_b)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        int data;
        bit hold;
        int fc;
        bit sat;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   got0[$];
    int   got1[$];
    bit   hold0[$];

    int  m_yprev [2];
    bit  m_first [2];
    int  m_acc   [2];
    int  m_fc    [2];
    bit  m_sat   [2];
    bit  prev_stall [2];
    int  prev_data  [2];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  lam_now;
    bit  lat_chk  = 1'b0;
    bit  pat [4];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_yprev[k] = 0;
            m_first[k] = 1'b1;
            m_acc[k]   = 0;
            m_fc[k]    = 0;
            m_sat[k]   = 1'b0;
        end
    endfunction

    // Reconstruction rules in plain integers: centre, difference, fold once,
    // accumulate with clipping to the instance's output range.
    function automatic exp_t model_step(int k, int code, bit skip, int lam);
        exp_t e;
        int   y, d, hi, lo;
        hi = (k == 0) ? (1 << 19) - 1 : (1 << 13) - 1;
        lo = -hi - 1;
        y  = code - 2048;
        if (skip) begin
            e.data = m_first[k] ? 0 : m_acc[k];
            e.hold = 1'b1;
        end else begin
            if (m_first[k]) begin
                m_acc[k] = y;
            end else begin
                d = y - m_yprev[k];
                if (d >= lam) begin
                    d = d - 2 * lam;
                    if (m_fc[k] < 65535) m_fc[k]++;
                end else if (d < -lam) begin
                    d = d + 2 * lam;
                    if (m_fc[k] < 65535) m_fc[k]++;
                end
                m_acc[k] = m_acc[k] + d;
                if (m_acc[k] > hi) begin
                    m_acc[k] = hi;
                    m_sat[k] = 1'b1;
                end else if (m_acc[k] < lo) begin
                    m_acc[k] = lo;
                    m_sat[k] = 1'b1;
                end
            end
            m_first[k] = 1'b0;
            m_yprev[k] = y;
            e.data = m_acc[k];
            e.hold = 1'b0;
        end
        e.fc  = m_fc[k];
        e.sat = m_sat[k];
        e.cyc = cyc;
        return e;
    endfunction

    task automatic mon_dut(int k, bit ov, bit ir, int od, bit oh, int fc, bit sat);
        exp_t e;
        int   qs;
        check($sformatf("in_ready_%0d", k), ir, (!ov || out_ready) ? 1 : 0);
        if (prev_stall[k] && ov) check($sformatf("stall_hold_%0d", k), od, prev_data[k]);
        prev_stall[k] = ov && !out_ready;
        prev_data[k]  = od;
        if (ov && out_ready) begin
            qs = (k == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                check($sformatf("out_without_input_%0d", k), qs, 1);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("out_data_%0d", k), od, e.data);
                check($sformatf("out_hold_%0d", k), oh, e.hold);
                check($sformatf("fold_count_%0d", k), fc, e.fc);
                check($sformatf("sat_flag_%0d", k), sat, e.sat);
                if (lat_chk) check($sformatf("latency_%0d", k), cyc - e.cyc, 2);
                if (k == 0) begin
                    got0.push_back(od);
                    hold0.push_back(oh);
                end else begin
                    got1.push_back(od);
                end
            end
        end
    endtask

    // Single compare process: checks outputs, then feeds the model with
    // whatever transfer the next edge will perform.
    always @(negedge adc_clk) begin
        cyc++;
        mon_dut(0, ifa.out_valid, ifa.in_ready, int'($signed(ifa.out_data)), ifa.out_hold, int'(fc_a), sat_a);
        mon_dut(1, ifb.out_valid, ifb.in_ready, int'($signed(ifb.out_data)), ifb.out_hold, int'(fc_b), sat_b);
        if (adc_reset || restart) begin
            q0.delete();
            q1.delete();
            model_reset();
        end else if (in_valid) begin
            lam_now = int'(fold_range[11:1]);
            if (ifa.in_ready) q0.push_back(model_step(0, int'(in_data), in_skip, lam_now));
            if (ifb.in_ready) q1.push_back(model_step(1, int'(in_data), in_skip, lam_now));
        end
    end

    task automatic send(int code, bit skip);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_data  = code[11:0];
        in_skip  = skip;
        @(negedge adc_clk);
        while (!ifa.in_ready && waitc < 100) begin
            @(negedge adc_clk);
            waitc++;
        end
        check("send_in_ready", int'(ifa.in_ready), 1);
        @(posedge adc_clk);
        #1;
        in_valid = 1'b0;
        in_skip  = 1'b0;
    endtask

    task automatic restart_pulse();
        restart = 1'b1;
        @(posedge adc_clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q0.size() != 0 || q1.size() != 0) && c < 60) begin
            @(posedge adc_clk);
            #1;
            c++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f;
        adc_reset  = 1'b1;
        restart    = 1'b0;
        in_valid   = 1'b0;
        in_skip    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        fold_range = 12'd1024;
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();

        // Reset and idle
        repeat (3) @(posedge adc_clk);
        #1;
        adc_reset = 1'b0;
        check("rst_out_valid", int'(ifa.out_valid), 0);
        check("rst_out_data", int'(ifa.out_data), 0);
        check("rst_out_hold", int'(ifa.out_hold), 0);
        check("rst_fold_count", int'(fc_a), 0);
        check("rst_sat_flag", int'(sat_a), 0);
        check("rst_in_ready", int'(ifa.in_ready), 1);
        check("rst_out_valid_b", int'(ifb.out_valid), 0);
        repeat (5) begin
            @(negedge adc_clk);
            check("idle_out_valid", int'(ifa.out_valid), 0);
        end
        @(posedge adc_clk);
        #1;

        // Unfold with one negative fold correction
        restart_pulse();
        got0.delete();
        lat_chk = 1'b1;
        send(2048, 0); send(2300, 0); send(2548, 0); send(1776, 0); send(2028, 0);
        drain();
        lat_chk = 1'b0;
        check("unfold_n", got0.size(), 5);
        check("unfold_0", got0[0], 0);
        check("unfold_1", got0[1], 252);
        check("unfold_2", got0[2], 500);
        check("unfold_3", got0[3], 752);
        check("unfold_4", got0[4], 1004);
        check("unfold_fc", int'(fc_a), 1);

        // Negative ramp with one positive fold correction
        restart_pulse();
        got0.delete();
        send(2048, 0); send(1848, 0); send(1648, 0); send(2472, 0);
        drain();
        check("neg_0", got0[0], 0);
        check("neg_1", got0[1], -200);
        check("neg_2", got0[2], -400);
        check("neg_3", got0[3], -600);
        check("neg_fc", int'(fc_a), 1);

        // Skip in the middle of a capture
        restart_pulse();
        got0.delete();
        hold0.delete();
        send(2048, 0); send(2300, 1); send(2548, 0);
        drain();
        check("skip_0", got0[0], 0);
        check("skip_1", got0[1], 0);
        check("skip_1_hold", int'(hold0[1]), 1);
        check("skip_2", got0[2], 500);
        check("skip_2_hold", int'(hold0[2]), 0);

        // Skip while still awaiting the first kept sample
        restart_pulse();
        got0.delete();
        hold0.delete();
        send(2300, 1); send(2100, 0);
        drain();
        check("skipfirst_0", got0[0], 0);
        check("skipfirst_0_hold", int'(hold0[0]), 1);
        check("skipfirst_1", got0[1], 52);

        // Backpressure with out_ready pattern 1,0,0,1
        restart_pulse();
        got0.delete();
        fork
            begin
                send(2048, 0); send(2100, 0); send(2200, 0); send(2300, 0); send(2400, 0);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    out_ready = pat[i % 4];
                    @(posedge adc_clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_n", got0.size(), 5);
        check("bp_0", got0[0], 0);
        check("bp_1", got0[1], 52);
        check("bp_2", got0[2], 152);
        check("bp_3", got0[3], 252);
        check("bp_4", got0[4], 352);

        // Ascending ramp of 300 per sample; the 14-bit instance clips
        restart_pulse();
        got0.delete();
        got1.delete();
        for (int i = 0; i < 32; i++) begin
            t = 300 * i;
            f = ((t + 512) % 1024) - 512;
            send(2048 + f, 0);
        end
        drain();
        check("ramp_b_27", got1[27], 8100);
        check("ramp_b_28", got1[28], 8191);
        check("ramp_b_31", got1[31], 8191);
        check("ramp_a_31", got0[31], 9300);
        check("ramp_sat_b", int'(sat_b), 1);
        check("ramp_sat_a", int'(sat_a), 0);
        check("ramp_fc_a", int'(fc_a), 9);

        // Restart with a sample in flight and another offered at the same edge
        send(2432, 0);
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'd1000;
        check("restart_in_ready", int'(ifa.in_ready), 1);
        @(posedge adc_clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        check("restart_out_valid", int'(ifb.out_valid), 0);
        check("restart_sat_b", int'(sat_b), 0);
        check("restart_fc_b", int'(fc_b), 0);
        got0.delete();
        got1.delete();
        repeat (3) @(posedge adc_clk);
        #1;
        check("restart_dropped", got0.size(), 0);
        send(3000, 0);
        drain();
        check("restart_n", got0.size(), 1);
        check("restart_a", got0[0], 952);
        check("restart_b", got1[0], 952);
        check("restart_sat_after", int'(sat_b), 0);
        check("restart_fc_after", int'(fc_b), 0);

        repeat (3) @(posedge adc_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
